// File: rtl/mem_lock_arbiter_pkg.sv
// Shared types and helpers for the memory-lock arbiter.
// Holds the lock state enum, the data-path widths and the modular age
// arithmetic used to decide which requester is oldest.
package mem_lock_arbiter_pkg;

  localparam int ADDR_W    = 30;
  localparam int DATA_W    = 32;
  localparam int STAT_W    = 32;
  // Widest issue id the age helpers handle; ID_WIDTH must not exceed it.
  localparam int AGE_MAX_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } lock_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Distance of an issue id from the head, modulo 2^id_width.
  // The subtraction is done at full helper width and then masked, which
  // gives the same result as a native id_width-bit wrap.
  function automatic logic [AGE_MAX_W-1:0] age_of(
    input logic [AGE_MAX_W-1:0] id,
    input logic [AGE_MAX_W-1:0] head,
    input int unsigned          id_width
  );
    logic [AGE_MAX_W-1:0] mask;
    if (id_width >= AGE_MAX_W) begin
      mask = '1;
    end else begin
      mask = (AGE_MAX_W'(1) << id_width) - AGE_MAX_W'(1);
    end
    return (id - head) & mask;
  endfunction

  // Strictly-older test; equal ages are not older so the earlier
  // (lower-index) candidate keeps the win on a tie.
  function automatic logic age_older(
    input logic [AGE_MAX_W-1:0] age_a,
    input logic [AGE_MAX_W-1:0] age_b
  );
    return age_a < age_b;
  endfunction

endpackage

// File: rtl/mem_lock_arbiter_age_picker.sv
// mem_age_picker: combinational oldest-request selection.
// Scans all requesters, measures each issue id relative to the head id
// and reports the lowest-index requester with the smallest age.
module mem_age_picker
  import mem_lock_arbiter_pkg::*;
#(
  parameter  int NUM_SIC  = 4,
  parameter  int ID_WIDTH = 6,
  localparam int IDX_W    = idx_width(NUM_SIC)
) (
  input  logic [NUM_SIC-1:0]          req,
  input  logic [NUM_SIC*ID_WIDTH-1:0] req_issue_id,
  input  logic [ID_WIDTH-1:0]         head_issue_id,
  output logic [IDX_W-1:0]            winner,
  output logic                        any_req
);

  logic [AGE_MAX_W-1:0] best_age;
  logic [AGE_MAX_W-1:0] cur_age;

  // Linear scan; a later index only takes over when strictly older.
  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    best_age = '1;
    cur_age  = '0;
    for (int i = 0; i < NUM_SIC; i++) begin
      cur_age = age_of(AGE_MAX_W'(req_issue_id[i*ID_WIDTH +: ID_WIDTH]),
                       AGE_MAX_W'(head_issue_id),
                       ID_WIDTH);
      if (req[i] && (!any_req || age_older(cur_age, best_age))) begin
        any_req  = 1'b1;
        best_age = cur_age;
        winner   = i[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_lock_arbiter.sv
// mem_lock_arbiter: grants one SIC at a time exclusive use of the shared
// data-memory port, oldest instruction first.
//
// Optional statistics outputs are built when MEM_LOCK_ARBITER_STATS_EN is
// defined; the default build has no counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; memory port parked at zero, oldest requester latched
// OWNED | owner register holds the SIC that has the port until it releases
//       | or withdraws its request
//
// Arbitration only happens from IDLE, so a release always costs one IDLE
// cycle before the next grant and a newly arriving older request can never
// pre-empt the current owner.
module mem_lock_arbiter
  import mem_lock_arbiter_pkg::*;
#(
  parameter  int NUM_SIC  = 4,
  parameter  int ID_WIDTH = 6,
  localparam int IDX_W    = idx_width(NUM_SIC)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ID_WIDTH-1:0]         head_issue_id,
  input  logic [NUM_SIC-1:0]          req,
  input  logic [NUM_SIC*ID_WIDTH-1:0] req_issue_id,
  input  logic [NUM_SIC-1:0]          release_lock,
  input  logic [NUM_SIC*ADDR_W-1:0]   sic_addr,
  input  logic [NUM_SIC*DATA_W-1:0]   sic_wdata,
  input  logic [NUM_SIC-1:0]          sic_wen,
  output logic [NUM_SIC-1:0]          grant,
  output logic [DATA_W-1:0]           sic_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_wen,
`ifdef MEM_LOCK_ARBITER_STATS_EN
  output logic [STAT_W-1:0]           stat_grants,
  output logic [STAT_W-1:0]           stat_wait_cycles,
`endif
  input  logic [DATA_W-1:0]           mem_rdata
);

  lock_state_e       state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  winner;
  logic              any_req;
  logic              owner_req;
  logic              owner_rel;

  mem_age_picker #(
    .NUM_SIC  (NUM_SIC),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req           (req),
    .req_issue_id  (req_issue_id),
    .head_issue_id (head_issue_id),
    .winner        (winner),
    .any_req       (any_req)
  );

  // Read data is broadcast unconditionally; only the owner acts on it.
  assign sic_rdata = mem_rdata;

  // Owner-side mux: grant follows the owner's live request so an abort
  // drops the grant (and any write) in the same cycle.
  always_comb begin
    grant     = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    owner_req = 1'b0;
    owner_rel = 1'b0;
    if (state == OWNED) begin
      for (int i = 0; i < NUM_SIC; i++) begin
        if (owner == i[IDX_W-1:0]) begin
          owner_req = req[i];
          owner_rel = release_lock[i];
          grant[i]  = req[i];
          mem_addr  = sic_addr[i*ADDR_W +: ADDR_W];
          mem_wdata = sic_wdata[i*DATA_W +: DATA_W];
          mem_wen   = sic_wen[i] & req[i];
        end
      end
    end
  end

  // Lock FSM: latch the oldest requester from IDLE, hold until the owner
  // releases or withdraws. Non-owner releases never reach owner_rel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= OWNED;
            owner <= winner;
          end
        end
        OWNED: begin
          if (owner_rel || !owner_req) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_LOCK_ARBITER_STATS_EN
  // Completed-transaction and starvation counters; both wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants      <= '0;
      stat_wait_cycles <= '0;
    end else begin
      if (owner_req && owner_rel && (state == OWNED)) begin
        stat_grants <= stat_grants + STAT_W'(1);
      end
      if ((|req) && (grant == '0)) begin
        stat_wait_cycles <= stat_wait_cycles + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Directed bench for mem_lock_arbiter: a per-cycle vector table plus a
// hand-written reset-while-owned sequence.
module tb_mem_lock_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   head_issue_id;
  logic [3:0]   req;
  logic [23:0]  req_issue_id;
  logic [3:0]   release_lock;
  logic [119:0] sic_addr;
  logic [127:0] sic_wdata;
  logic [3:0]   sic_wen;
  logic [3:0]   grant;
  logic [31:0]  sic_rdata;
  logic [29:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_wen;
  logic [31:0]  mem_rdata;
`ifdef MEM_LOCK_ARBITER_STATS_EN
  logic [31:0]  stat_grants;
  logic [31:0]  stat_wait_cycles;
`endif

  int errors = 0;
  int checks = 0;

  mem_lock_arbiter #(.NUM_SIC(4), .ID_WIDTH(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .head_issue_id (head_issue_id),
    .req           (req),
    .req_issue_id  (req_issue_id),
    .release_lock  (release_lock),
    .sic_addr      (sic_addr),
    .sic_wdata     (sic_wdata),
    .sic_wen       (sic_wen),
    .grant         (grant),
    .sic_rdata     (sic_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wen       (mem_wen),
`ifdef MEM_LOCK_ARBITER_STATS_EN
    .stat_grants      (stat_grants),
    .stat_wait_cycles (stat_wait_cycles),
`endif
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  req;
    logic [23:0] ids;
    logic [5:0]  head;
    logic [3:0]  rel;
    logic [3:0]  wen;
    logic [3:0]  eg;
    logic        ew;
    int          eo;   // expected owner driving the port, -1 when IDLE
  } vec_t;

  vec_t vq[$];

  logic [29:0] addr_tbl [4] = '{30'h40, 30'h50, 30'h10, 30'h70};
  logic [31:0] data_tbl [4] = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};

  function automatic logic [23:0] ids4(input logic [5:0] i0, i1, i2, i3);
    return {i3, i2, i1, i0};
  endfunction

  function automatic void add(input logic [3:0] rq, input logic [23:0] ids,
                              input logic [5:0] hd, input logic [3:0] rl,
                              input logic [3:0] wn, input logic [3:0] eg,
                              input logic ew, input int eo);
    vec_t v;
    v.req = rq; v.ids = ids; v.head = hd; v.rel = rl; v.wen = wn;
    v.eg = eg; v.ew = ew; v.eo = eo;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rq, input logic [23:0] ids, input logic [5:0] hd,
                       input logic [3:0] rl, input logic [3:0] wn);
    req = rq; req_issue_id = ids; head_issue_id = hd; release_lock = rl; sic_wen = wn;
  endtask

  initial begin
    logic [23:0] i_single, i_wrap, i_tie, i_abort, i_pre;
    logic [29:0] ea;
    logic [31:0] ed;

    i_single = ids4(6'd0, 6'd0, 6'd5, 6'd0);
    i_wrap   = ids4(6'd2, 6'd62, 6'd0, 6'd0);
    i_tie    = ids4(6'd0, 6'd7, 6'd0, 6'd7);
    i_abort  = ids4(6'd1, 6'd0, 6'd0, 6'd3);
    i_pre    = ids4(6'd10, 6'd0, 6'd0, 6'd2);

    //   req      ids       head   rel      wen      grant   wen  owner
    // single request, write on release, then IDLE gap
    add(4'b0100, i_single, 6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    add(4'b0100, i_single, 6'd0,  4'b0100, 4'b0100, 4'b0100, 1'b1,  2);
    add(4'b0100, i_single, 6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    add(4'b0100, i_single, 6'd0,  4'b0100, 4'b0000, 4'b0100, 1'b0,  2);
    add(4'b0000, i_single, 6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    // wrap-around age: head 60, SIC1 id 62 (age 2) beats SIC0 id 2 (age 6)
    add(4'b0011, i_wrap,   6'd60, 4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    add(4'b0011, i_wrap,   6'd60, 4'b0000, 4'b0011, 4'b0010, 1'b1,  1);
    add(4'b0011, i_wrap,   6'd60, 4'b0010, 4'b0000, 4'b0010, 1'b0,  1);
    add(4'b0001, i_wrap,   6'd60, 4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    add(4'b0001, i_wrap,   6'd60, 4'b0001, 4'b0001, 4'b0001, 1'b1,  0);
    add(4'b0000, i_wrap,   6'd60, 4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    // tie on id 7: lower index SIC1 wins
    add(4'b1010, i_tie,    6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    add(4'b1010, i_tie,    6'd0,  4'b0010, 4'b0000, 4'b0010, 1'b0,  1);
    add(4'b1000, i_tie,    6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    add(4'b1000, i_tie,    6'd0,  4'b1000, 4'b0000, 4'b1000, 1'b0,  3);
    add(4'b0000, i_tie,    6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    // abort: SIC0 drops req with wen still high, SIC3 follows
    add(4'b1001, i_abort,  6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    add(4'b1001, i_abort,  6'd0,  4'b0000, 4'b1001, 4'b0001, 1'b1,  0);
    add(4'b1000, i_abort,  6'd0,  4'b0000, 4'b1001, 4'b0000, 1'b0,  0);
    add(4'b1000, i_abort,  6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    add(4'b1000, i_abort,  6'd0,  4'b1000, 4'b0000, 4'b1000, 1'b0,  3);
    add(4'b0000, i_abort,  6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    // no pre-emption by older SIC3; SIC3 release while not owner ignored
    add(4'b0001, i_pre,    6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    add(4'b1001, i_pre,    6'd0,  4'b1000, 4'b0000, 4'b0001, 1'b0,  0);
    add(4'b1001, i_pre,    6'd0,  4'b0000, 4'b0000, 4'b0001, 1'b0,  0);
    add(4'b1001, i_pre,    6'd0,  4'b0001, 4'b1000, 4'b0001, 1'b0,  0);
    add(4'b1000, i_pre,    6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
    add(4'b1000, i_pre,    6'd0,  4'b1000, 4'b1000, 4'b1000, 1'b1,  3);
    add(4'b0000, i_pre,    6'd0,  4'b0000, 4'b0000, 4'b0000, 1'b0, -1);

    for (int i = 0; i < 4; i++) begin
      sic_addr[i*30 +: 30]  = addr_tbl[i];
      sic_wdata[i*32 +: 32] = data_tbl[i];
    end
    rst_n = 1'b0;
    mem_rdata = 32'h0;
    drive(4'b0000, 24'h0, 6'd0, 4'b0000, 4'b0000);
    #1;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_mem_wen", 32'(mem_wen), 32'h0);
    check("reset_mem_addr", 32'(mem_addr), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      drive(vq[k].req, vq[k].ids, vq[k].head, vq[k].rel, vq[k].wen);
      mem_rdata = 32'h5A5A_0000 ^ 32'(k);
      ea = (vq[k].eo < 0) ? 30'h0 : addr_tbl[vq[k].eo];
      ed = (vq[k].eo < 0) ? 32'h0 : data_tbl[vq[k].eo];
      #1;
      check($sformatf("row%0d_grant", k), 32'(grant), 32'(vq[k].eg));
      check($sformatf("row%0d_mem_wen", k), 32'(mem_wen), 32'(vq[k].ew));
      check($sformatf("row%0d_mem_addr", k), 32'(mem_addr), 32'(ea));
      check($sformatf("row%0d_mem_wdata", k), mem_wdata, ed);
      check($sformatf("row%0d_sic_rdata", k), sic_rdata, 32'h5A5A_0000 ^ 32'(k));
    end

    @(negedge clk);
    drive(4'b0000, 24'h0, 6'd0, 4'b0000, 4'b0000);
    #1;
`ifdef MEM_LOCK_ARBITER_STATS_EN
    check("stat_grants_total", stat_grants, 32'd9);
    check("stat_wait_total", stat_wait_cycles, 32'd11);
`endif

    // reset while OWNED with a write pending
    @(negedge clk);
    drive(4'b0100, i_single, 6'd0, 4'b0000, 4'b0100);
    @(negedge clk);
    #1;
    check("pre_reset_grant", 32'(grant), 32'h4);
    check("pre_reset_mem_wen", 32'(mem_wen), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_grant", 32'(grant), 32'h0);
    check("async_reset_mem_wen", 32'(mem_wen), 32'h0);
    check("async_reset_mem_addr", 32'(mem_addr), 32'h0);
`ifdef MEM_LOCK_ARBITER_STATS_EN
    check("reset_stat_grants", stat_grants, 32'h0);
    check("reset_stat_wait", stat_wait_cycles, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_idle_grant", 32'(grant), 32'h0);
    @(negedge clk);
    #1;
    check("post_reset_regrant", 32'(grant), 32'h4);
    check("post_reset_regrant_addr", 32'(mem_addr), 32'h10);
    release_lock = 4'b0100;
    @(negedge clk);
    drive(4'b0000, 24'h0, 6'd0, 4'b0000, 4'b0000);
    #1;
    check("final_idle_grant", 32'(grant), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lock_arbiter.md
MEM_LOCK_ARBITER -- requirements
Module: mem_lock_arbiter

Interface
REQ-001 Parameter NUM_SIC, default 4: number of SIC execution units sharing one data-memory port.
REQ-002 Parameter ID_WIDTH, default 6: issue-id width, modulo-2^ID_WIDTH wrap.
REQ-003 clk  input  1: single clock, all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 head_issue_id  input  ID_WIDTH: issue id of the oldest in-flight instruction, the age origin.
REQ-006 req  input  NUM_SIC: per-SIC memory-lock request.
REQ-007 req_issue_id  input  NUM_SIC x ID_WIDTH: per-SIC issue id of the requesting instruction.
REQ-008 release_lock  input  NUM_SIC: per-SIC lock release, asserted in the grant cycle.
REQ-009 sic_addr / sic_wdata / sic_wen  input  NUM_SIC x 30 / 32 / 1: per-SIC word address, write data, write enable.
REQ-010 grant  output  NUM_SIC: one-hot memory grant.
REQ-011 sic_rdata  output  32: read data broadcast to all SICs.
REQ-012 mem_addr / mem_wdata / mem_wen  output  30 / 32 / 1: shared memory port, asynchronous read, write on clk edge.
REQ-013 mem_rdata  input  32: memory read data.

Function
REQ-014 States are IDLE and OWNED, plus an owner index register.
REQ-015 Age per requester = (req_issue_id - head_issue_id) mod 2^ID_WIDTH; the smallest age wins; ties go to the lowest index.
REQ-016 In IDLE with any req high, the block latches the winner as owner and enters OWNED at the next edge. With no req, it stays in IDLE.
REQ-017 In OWNED, grant[owner] = req[owner]. Every other grant bit is 0. Latency from req to grant is 1 cycle minimum.
REQ-018 In OWNED, mem_addr and mem_wdata mux from the owner, and mem_wen = sic_wen[owner] & grant[owner].
REQ-019 sic_rdata = mem_rdata combinationally in every cycle.
REQ-020 OWNED returns to IDLE at the next edge when release_lock[owner] is high or req[owner] is low (abort); no memory write occurs on abort.
REQ-021 A new arbitration is never performed in the cycle the lock is released. This gives at least one IDLE cycle between grants.
REQ-022 A request arriving while OWNED waits and is not pre-empted, even if it is older.
REQ-023 In IDLE, grant = 0 and mem_wen = 0; mem_addr and mem_wdata drive 0.
REQ-024 release_lock from a non-owner is ignored.

Reset
REQ-025 Asynchronous reset asserted: state becomes IDLE, owner becomes 0, grant = 0, and mem_wen = 0 immediately.
REQ-026 Reset while OWNED drops the lock with no write. All statistics counters clear to 0.

Configuration
REQ-027 Macro MEM_LOCK_ARBITER_STATS_EN, when defined, adds two outputs: stat_grants (32 bit) and stat_wait_cycles (32 bit).
REQ-028 stat_grants increments on each cycle where grant[owner] & release_lock[owner].
REQ-029 stat_wait_cycles increments on each cycle where some req is high and grant is 0. Both counters wrap.
REQ-030 Without the macro, these outputs and counters do not exist and behaviour is otherwise identical.

Structure
REQ-031 The shared package holds the state enum (IDLE, OWNED) and the age-compare function, parameterised by ID_WIDTH.
REQ-032 One sub-module, mem_age_picker, provides the combinational oldest-request selection, outputting winner index and any_req.

Verification
REQ-033 Single request: SIC2 req, id 5, head 0, at cycle 0. Required: grant=0b0100 at cycle 1. With sic_wen=1, sic_addr=0x10 and release at cycle 1, mem_wen=1 at cycle 1 and state is IDLE at cycle 2.
REQ-034 Age order with wrap: ID_WIDTH 6, head 60; SIC0 id 2, SIC1 id 62. Required: SIC1 granted first, then SIC0 after SIC1 releases plus one IDLE cycle.
REQ-035 Tie: SIC1 and SIC3 both id 7. Required: SIC1 wins.
REQ-036 Abort: the owner drops req in OWNED without release. Required: grant=0, mem_wen=0, IDLE next cycle, and the next requester is granted one cycle later.
REQ-037 No pre-emption: SIC0 owns the lock and an older SIC3 request arrives. Required: grant stays with SIC0 until release.
REQ-038 Reset mid-OWNED with wen pending. Required: grant=0 and mem_wen=0 asynchronously, state IDLE. With STATS_EN, both counters read 0.
